// File: rtl/rr_stage_arb_pkg.sv
// Shared arbitration helpers: ceiling log2 and the source-id width derived from it.
// Reused by every arbiter that encodes a requester index.
package rr_stage_arb_pkg;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // A single requester still needs a 1-bit index so ports never collapse to zero width.
    function automatic int idw_for(input int n);
        return (n < 2) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/rr_stage_arb_pick.sv
// Combinational rotate-priority picker: first set req bit at or after ptr, wrapping at NREQ.
// Works for non-power-of-two NREQ because the wrap is done explicitly, not by overflow.
module rr_pick
    import rr_stage_arb_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IDW = idw_for(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] sel,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    always_comb begin
        int cand;
        sel  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!any && req[cand[IDW-1:0]]) begin
                any                 = 1'b1;
                idx                 = cand[IDW-1:0];
                sel[cand[IDW-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_stage_arb.sv
// One registered output stage shared by NREQ requesters under round-robin priority.
// The word register is refilled whenever it is empty or being drained at the same edge.
module rr_stage_arb
    import rr_stage_arb_pkg::*;
#(
    parameter int               NREQ        = 4,
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              IDW         = idw_for(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] idat,
    output logic [NREQ-1:0]       gnt,
    output logic                  ovld,
    output logic [WIDTH-1:0]      odat,
    output logic [IDW-1:0]        osrc,
    input  logic                  ordy
);

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic             ovld_q, ovld_d;
    logic [WIDTH-1:0] odat_q, odat_d;
    logic [IDW-1:0]   osrc_q, osrc_d;

    logic [NREQ-1:0]  pick_sel;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;
    logic [WIDTH-1:0] pick_word;
    logic             take;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req (req),
        .ptr (ptr_q),
        .sel (pick_sel),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        pick_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IDW'(i)) begin
                pick_word = idat[i*WIDTH +: WIDTH];
            end
        end
    end

    assign take = !rst && pick_any && (!ovld_q || ordy);
    assign gnt  = take ? pick_sel : '0;

    always_comb begin
        ptr_d  = ptr_q;
        ovld_d = ovld_q;
        odat_d = odat_q;
        osrc_d = osrc_q;
        if (take) begin
            odat_d = pick_word;
            osrc_d = pick_idx;
            ovld_d = 1'b1;
            ptr_d  = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
        end else if (ovld_q && ordy) begin
            ovld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= '0;
            ovld_q <= 1'b0;
            odat_q <= RESET_VALUE;
            osrc_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            ovld_q <= ovld_d;
            odat_q <= odat_d;
            osrc_q <= osrc_d;
        end
    end

    assign ovld = ovld_q;
    assign odat = odat_q;
    assign osrc = osrc_q;

endmodule

// File: tb/tb_rr_stage_arb.sv
// Bench for rr_stage_arb: 4-requester instance against a reference model and scoreboard,
// plus a 3-requester instance exercising pointer wrap.
module tb_rr_stage_arb;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] idat;
    logic [3:0]  gnt;
    logic        ovld;
    logic [7:0]  odat;
    logic [1:0]  osrc;
    logic        ordy;

    logic        rst3;
    logic [2:0]  req3;
    logic [23:0] idat3;
    logic [2:0]  gnt3;
    logic        ovld3;
    logic [7:0]  odat3;
    logic [1:0]  osrc3;
    logic        ordy3;

    int checks;
    int errors;

    logic [1:0]  m_ptr;
    logic        m_ovld;
    logic [9:0]  exp_q[$];

    typedef struct {
        logic [3:0]  req;
        logic [31:0] idat;
        logic        ordy;
        logic [3:0]  gnt;
    } vec_t;

    typedef struct {
        logic [2:0] req;
        logic [2:0] gnt;
        logic       ovld;
        logic [1:0] osrc;
    } vec3_t;

    vec_t  vecs[16];
    vec3_t vecs3[8];

    rr_stage_arb #(.NREQ(4), .WIDTH(8), .RESET_VALUE(8'h00)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .idat (idat),
        .gnt  (gnt),
        .ovld (ovld),
        .odat (odat),
        .osrc (osrc),
        .ordy (ordy)
    );

    rr_stage_arb #(.NREQ(3), .WIDTH(8), .RESET_VALUE(8'h00)) dut3 (
        .clk  (clk),
        .rst  (rst3),
        .req  (req3),
        .idat (idat3),
        .gnt  (gnt3),
        .ovld (ovld3),
        .odat (odat3),
        .osrc (osrc3),
        .ordy (ordy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1;
            #1;
            chk("rst_gnt", 32'(gnt), 32'h0);
            if (i > 0) begin
                chk("rst_ovld", 32'(ovld), 32'h0);
                chk("rst_odat", 32'(odat), 32'h0);
                chk("rst_osrc", 32'(osrc), 32'h0);
            end
        end
        m_ptr  = 2'd0;
        m_ovld = 1'b0;
        exp_q.delete();
    endtask

    // Drive one cycle, compare against model and table, then advance the model past the edge.
    task automatic step(input logic [3:0] r, input logic [31:0] d, input logic rdy,
                        input logic [3:0] tab_g);
        logic [3:0] mg;
        logic [1:0] c;
        logic [1:0] w;
        int         win;
        @(negedge clk);
        rst  = 1'b0;
        req  = r;
        idat = d;
        ordy = rdy;
        #1;
        win = -1;
        if (!m_ovld || rdy) begin
            for (int k = 0; k < 4; k++) begin
                c = m_ptr + 2'(k);
                if (win < 0 && r[c]) win = int'(c);
            end
        end
        mg = (win >= 0) ? 4'(1 << win) : 4'b0;
        chk("gnt_model", 32'(gnt), 32'(mg));
        chk("gnt_table", 32'(gnt), 32'(tab_g));
        chk("ovld", 32'(ovld), 32'(m_ovld));
        if (m_ovld) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: ovld=1 with no expected word at %0t", $time);
            end else begin
                chk("odat", 32'(odat), 32'(exp_q[0][7:0]));
                chk("osrc", 32'(osrc), 32'(exp_q[0][9:8]));
                if (rdy) void'(exp_q.pop_front());
            end
        end
        if (win >= 0) begin
            w = 2'(win);
            exp_q.push_back({w, d[w*8 +: 8]});
            m_ptr  = w + 2'd1;
            m_ovld = 1'b1;
        end else if (m_ovld && rdy) begin
            m_ovld = 1'b0;
        end
    endtask

    task automatic step3(input vec3_t v);
        @(negedge clk);
        rst3 = 1'b0;
        req3 = v.req;
        #1;
        chk("n3_gnt", 32'(gnt3), 32'(v.gnt));
        chk("n3_ovld", 32'(ovld3), 32'(v.ovld));
        if (v.ovld) begin
            chk("n3_osrc", 32'(osrc3), 32'(v.osrc));
            chk("n3_odat", 32'(odat3), 32'(idat3[v.osrc*8 +: 8]));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        req    = '0;
        idat   = '0;
        ordy   = 1'b1;
        rst3   = 1'b1;
        req3   = '0;
        idat3  = {8'hC2, 8'hB1, 8'hA0};
        ordy3  = 1'b1;
        m_ptr  = 2'd0;
        m_ovld = 1'b0;

        vecs[0]  = '{4'b0100, 32'h0, 1'b1, 4'b0100};
        vecs[1]  = '{4'b0000, 32'h0, 1'b0, 4'b0000};
        vecs[2]  = '{4'b1001, 32'h0, 1'b1, 4'b1000};
        vecs[3]  = '{4'b1001, 32'h0, 1'b1, 4'b0001};
        vecs[4]  = '{4'b1111, 32'h0, 1'b1, 4'b0010};
        vecs[5]  = '{4'b1111, 32'h0, 1'b1, 4'b0100};
        vecs[6]  = '{4'b1111, 32'h0, 1'b1, 4'b1000};
        vecs[7]  = '{4'b1111, 32'h0, 1'b1, 4'b0001};
        vecs[8]  = '{4'b0000, 32'h0, 1'b1, 4'b0000};
        vecs[9]  = '{4'b0000, 32'h0, 1'b1, 4'b0000};
        vecs[10] = '{4'b0001, 32'h0, 1'b0, 4'b0001};
        vecs[11] = '{4'b0110, 32'h0, 1'b0, 4'b0000};
        vecs[12] = '{4'b0110, 32'h0, 1'b1, 4'b0010};
        vecs[13] = '{4'b0101, 32'h0, 1'b1, 4'b0100};
        vecs[14] = '{4'b0011, 32'h0, 1'b1, 4'b0001};
        vecs[15] = '{4'b0000, 32'h0, 1'b1, 4'b0000};
        for (int i = 0; i < 16; i++) vecs[i].idat = $urandom();
        vecs[0].idat[23:16] = 8'h3C;

        // Table vectors from a clean reset.
        do_reset(2);
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].req, vecs[i].idat, vecs[i].ordy, vecs[i].gnt);
        end

        // All requesters held high: strict rotation, no bubbles.
        do_reset(2);
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, $urandom(), 1'b1, 4'(1 << (i % 4)));
        end
        step(4'b0000, 32'h0, 1'b1, 4'b0000);
        step(4'b0000, 32'h0, 1'b1, 4'b0000);

        // Downstream stall with a waiting requester, then drain and refill at one edge.
        do_reset(2);
        step(4'b0001, 32'h0000_0055, 1'b1, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            step(4'b0010, 32'h0000_7700 | 32'($urandom_range(0, 255)), 1'b0, 4'b0000);
        end
        step(4'b0010, 32'h0000_9900, 1'b1, 4'b0010);
        step(4'b0000, 32'h0, 1'b1, 4'b0000);
        step(4'b0000, 32'h0, 1'b1, 4'b0000);

        // Reset while full: word discarded, pointer back to 0.
        do_reset(2);
        step(4'b0100, 32'h00A5_0000, 1'b0, 4'b0100);
        step(4'b0100, 32'h00A5_0000, 1'b0, 4'b0000);
        do_reset(3);
        step(4'b1001, 32'h4400_0011, 1'b1, 4'b0001);
        step(4'b0000, 32'h0, 1'b1, 4'b0000);
        step(4'b0000, 32'h0, 1'b1, 4'b0000);

        // Three-requester instance: pointer wraps 2 -> 0.
        vecs3[0] = '{3'b100, 3'b100, 1'b0, 2'd0};
        vecs3[1] = '{3'b100, 3'b100, 1'b1, 2'd2};
        vecs3[2] = '{3'b100, 3'b100, 1'b1, 2'd2};
        vecs3[3] = '{3'b011, 3'b001, 1'b1, 2'd2};
        vecs3[4] = '{3'b111, 3'b010, 1'b1, 2'd0};
        vecs3[5] = '{3'b111, 3'b100, 1'b1, 2'd1};
        vecs3[6] = '{3'b111, 3'b001, 1'b1, 2'd2};
        vecs3[7] = '{3'b000, 3'b000, 1'b1, 2'd0};
        @(negedge clk);
        rst3 = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) step3(vecs3[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_stage_arb.md
# rr_stage_arb

Round-robin arbiter that shares one registered pipeline stage between NREQ requesters. Each cycle the stage is free, it selects one pending requester, acknowledges it with a one-cycle grant, and captures that requester's word into a single output register. The register is drained downstream through a valid/ready handshake. It sits in front of shared datapath resources, such as a single NTT butterfly or hash-core input port fed by several sequencers.

## Interface
- NREQ, 4, number of requesters (2..16)
- WIDTH, 8, data word width
- RESET_VALUE, {WIDTH{1'b0}}, odat value after reset
- IDW, $clog2(NREQ), width of source id (derived, not overridden)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset; the only reset in the block
- req  in  NREQ  per-requester request; held high with its data until granted
- idat  in  NREQ*WIDTH  requester data; requester i occupies bits [i*WIDTH +: WIDTH]
- gnt  out  NREQ  one-hot, combinational; high = word consumed at this edge
- ovld  out  1  output register holds a valid word
- odat  out  WIDTH  registered output word
- osrc  out  IDW  index of the requester that supplied odat
- ordy  in  1  downstream accepts odat at this edge when ovld=1

## Operation
- Stage state: EMPTY (ovld=0) and FULL (ovld=1), held in the ovld flop.
- take = !rst && |req && (!ovld || ordy).
- Winner selection: first i with req[i]=1, searching ptr, ptr+1, … wrapping modulo NREQ.
- gnt[winner] = take; all other gnt bits are 0. gnt is all zeros while rst=1.
- On the edge with take=1: odat <= idat[winner], osrc <= winner, ovld <= 1, ptr <= (winner+1) mod NREQ. ptr wraps NREQ-1 -> 0.
- On the edge with ovld && ordy && !take: ovld <= 0. odat and osrc hold their values.
- FULL with ordy=0: gnt=0, and odat, osrc and ptr all hold. Requesters stall.
- ptr changes only on take. Idle cycles do not rotate priority.
- A requester that deasserts req before it is granted is dropped silently. No state is kept per requester.
- Reset (any cycle, including while FULL): ovld=0, odat=RESET_VALUE, osrc=0, ptr=0. An in-flight word is discarded.
- Non-power-of-two NREQ is supported. ptr never takes values ≥ NREQ.

## Timing
- Latency: req seen at edge N with stage free -> ovld=1, odat valid after edge N.
- Throughput: one word per cycle when ordy is held high.
- Simultaneous drain and fill: when FULL with ordy=1 and a pending req, the old word leaves and the new word loads at the same edge. ovld stays 1 with no bubble.
- Fairness: with all req bits held high, each requester is granted exactly once every NREQ grants.
- gnt has a combinational path from req, ovld, ordy and ptr. No combinational path exists from idat to any output.
- First edge after rst deasserts: take is permitted.

## Structure
- Shared package (kyber arbitration pkg): clog2 helper function and the IDW derivation. The package is reused by other arbiters.
- One sub-module, rr_pick: purely combinational rotate-priority picker.
  - Inputs: req, ptr.
  - Outputs: one-hot sel, encoded idx, any.
- rr_stage_arb holds:
  - the ptr, ovld, odat and osrc flops;
  - the take logic;
  - the idat mux, indexed by the rr_pick idx.

## Test plan
- Reset while FULL holding 0xA5 from src 2 -> next cycle ovld=0, odat=0x00, osrc=0, ptr=0; gnt=0 throughout reset.
- NREQ=4, all req held high, ordy=1 for 8 cycles -> gnt sequence 0,1,2,3,0,1,2,3; ovld stays 1 from the first edge; osrc follows one cycle later.
- Only req[2]=1 with idat=0x3C, stage EMPTY -> gnt=0100 for one cycle; next cycle ovld=1, odat=0x3C, osrc=2; ptr=3.
- FULL, ordy=0 for 5 cycles with req[1] high -> gnt=0 and odat stable; on the first cycle ordy=1, gnt[1]=1 and odat is replaced at that edge with no bubble.
- req[3] and req[0] both high, ptr=3 -> grant 3 first, then 0; ptr reads 0 then 1.
- NREQ=3, repeated grants to requester 2 -> ptr wraps to 0 and never reads 3; osrc width is 2.
